// File: rtl/uart_rx_frame.sv
// UART receiver: start + 8 data (LSB first) + stop, sampled at mid-bit from a synchronized line.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit sampled before the stop bit.
module uart_rx_frame #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] op_data,
    output logic       op_flag,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int BIT_MAX = CLK_FREQ / BAUD - 1;
    localparam int MID     = BIT_MAX / 2;
    localparam int CW      = (BIT_MAX > 0) ? $clog2(BIT_MAX + 1) : 1;
    localparam logic [CW-1:0] BIT_MAX_C = CW'(BIT_MAX);
    localparam logic [CW-1:0] MID_C     = CW'(MID);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

    state_e        state_q;
    logic          rx_s1_q, rx_s2_q, rx_hist_q;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    op_data_q;
    logic          op_flag_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_q;
    logic          par_bad_q;
`endif

    logic sample;
    logic cnt_run;

    assign sample = (baud_cnt_q == MID_C);

    // The counter is parked at 0 in IDLE/WAIT_HIGH, including the cycle a frame ends there.
    assign cnt_run = !(state_q inside {IDLE, WAIT_HIGH})
                  && !(sample && (state_q == STOP || (state_q == START && rx_s2_q)));

    // NOTE: combinational next-state gets a default first so no latch is inferred.
    always_comb begin
        baud_cnt_d = '0;
        if (cnt_run && baud_cnt_q != BIT_MAX_C) begin
            baud_cnt_d = baud_cnt_q + CW'(1);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            // NOTE: synchronizer flops reset to the idle-line level so release cannot fake a start edge.
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_hist_q   <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            op_data_q   <= 8'h00;
            op_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_hist_q   <= rx_s2_q;
            baud_cnt_q  <= baud_cnt_d;
            op_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_hist_q && !rx_s2_q) state_q <= START;
                end
                START: begin
                    if (sample) state_q <= rx_s2_q ? IDLE : DATA;
                end
                DATA: begin
                    if (sample) begin
                        shift_q   <= {rx_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_bad_q <= ^{rx_s2_q, shift_q};
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge half a bit later be caught.
                    if (sample) begin
                        if (!rx_s2_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_q) begin
                            parity_err_q <= 1'b1;
                            state_q      <= IDLE;
                        end
`endif
                        else begin
                            op_data_q <= shift_q;
                            op_flag_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s2_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_data   = op_data_q;
    assign op_flag   = op_flag_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at 9600 baud with a 64x clock to keep runs short.
// Expected pulses are queued when frames are sent and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int BAUD     = 9600;
    localparam int BIT_CYC  = 64;
    localparam int CLK_FREQ = BAUD * BIT_CYC;
    // Same fraction of a bit as 1000 cycles of a 5208-cycle bit: well short of the mid-bit sample.
    localparam int GLITCH   = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] op_data;
    logic       op_flag, frame_err, parity_err, busy;

    uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .op_data   (op_data),
        .op_flag   (op_flag),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_FLAG, EV_FERR, EV_PERR} ev_e;
    typedef struct packed {
        ev_e        kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  flag_cnt = 0;
    int  ferr_cnt = 0;
    int  perr_cnt = 0;

    // Monitor: every output pulse must be single and match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        ev_t got;
        ev_t want;
        if (rst_n && (op_flag || frame_err || parity_err)) begin
            got.kind = op_flag ? EV_FLAG : (frame_err ? EV_FERR : EV_PERR);
            got.data = op_data;
            if (op_flag)    flag_cnt++;
            if (frame_err)  ferr_cnt++;
            if (parity_err) perr_cnt++;
            n_checks++;
            if ($countones({op_flag, frame_err, parity_err}) != 1) begin
                n_fail++;
                $display("FAIL pulse_exclusive: flag/ferr/perr=%b%b%b, required one-hot",
                         op_flag, frame_err, parity_err);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: kind=%0d data=%h, required no pulse",
                         got.kind, got.data);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL scoreboard: kind=%0d data=%h, required kind=%0d data=%h",
                             got.kind, got.data, want.kind, want.data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BIT_CYC - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic send_ok(input logic [7:0] d);
        exp_q.push_back('{kind: EV_FLAG, data: d});
        send_frame(d, 1'b1, even_par(d));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (op_data !== 8'h00) begin n_fail++; $display("FAIL reset_op_data: %h, required 00", op_data); end
        if (op_flag !== 1'b0) begin n_fail++; $display("FAIL reset_op_flag: %b, required 0", op_flag); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: %b, required 0", frame_err); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: %b, required 0", parity_err); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
        rst_n = 1'b1;
        idle(8);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: %b, required 0", busy); end
    endtask

    task automatic test_single();
        int f0 = flag_cnt;
        int e0 = ferr_cnt + perr_cnt;
        send_ok(8'h55);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_stop: %b, required 0", busy); end
        wait_drain("single", 4 * BIT_CYC);
        n_checks += 3;
        if (op_data !== 8'h55) begin n_fail++; $display("FAIL single_data: %h, required 55", op_data); end
        if (flag_cnt != f0 + 1) begin n_fail++; $display("FAIL single_flag_count: %0d, required %0d", flag_cnt - f0, 1); end
        if (ferr_cnt + perr_cnt != e0) begin n_fail++; $display("FAIL single_err_count: %0d, required 0", ferr_cnt + perr_cnt - e0); end
        idle(BIT_CYC);
    endtask

    task automatic test_glitch();
        int f0 = flag_cnt;
        int e0 = ferr_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (GLITCH) @(negedge clk);
        rx = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_detect: busy=%b, required 1", busy); end
        repeat (BIT_CYC) @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_return_idle: busy=%b, required 0", busy); end
        if (flag_cnt != f0) begin n_fail++; $display("FAIL glitch_flag: %0d pulses, required 0", flag_cnt - f0); end
        if (ferr_cnt != e0) begin n_fail++; $display("FAIL glitch_ferr: %0d pulses, required 0", ferr_cnt - e0); end
    endtask

    task automatic test_frame_err();
        int f0 = flag_cnt;
        int e0 = ferr_cnt;
        exp_q.push_back('{kind: EV_FERR, data: 8'h55});
        send_frame(8'hA5, 1'b0, even_par(8'hA5));
        repeat (3 * BIT_CYC) @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: %b, required 1", busy); end
        if (ferr_cnt != e0 + 1) begin n_fail++; $display("FAIL break_ferr_count: %0d, required 1", ferr_cnt - e0); end
        if (flag_cnt != f0) begin n_fail++; $display("FAIL break_flag_count: %0d, required 0", flag_cnt - f0); end
        if (op_data !== 8'h55) begin n_fail++; $display("FAIL break_data_held: %h, required 55", op_data); end
        wait_drain("frame_err", 4);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_rearm_idle: busy=%b, required 0", busy); end
        send_ok(8'h5A);
        wait_drain("rearm", 4 * BIT_CYC);
        n_checks++;
        if (op_data !== 8'h5A) begin n_fail++; $display("FAIL rearm_data: %h, required 5a", op_data); end
        idle(BIT_CYC);
    endtask

    task automatic test_back_to_back();
        int f0 = flag_cnt;
        send_ok(8'hA5);
        send_ok(8'h3C);
        wait_drain("back_to_back", 4 * BIT_CYC);
        n_checks += 2;
        if (op_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_last_data: %h, required 3c", op_data); end
        if (flag_cnt != f0 + 2) begin n_fail++; $display("FAIL b2b_flag_count: %0d, required 2", flag_cnt - f0); end
        idle(BIT_CYC);
    endtask

    task automatic test_reset_mid();
        int f0 = flag_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CYC / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: %b, required 0", busy); end
        if (op_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: %h, required 00", op_data); end
        rst_n = 1'b1;
        idle(2 * BIT_CYC);
        n_checks += 2;
        if (flag_cnt != f0) begin n_fail++; $display("FAIL midreset_no_pulse: %0d pulses, required 0", flag_cnt - f0); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: busy=%b, required 0", busy); end
        send_ok(8'h12);
        wait_drain("after_reset", 4 * BIT_CYC);
        n_checks++;
        if (op_data !== 8'h12) begin n_fail++; $display("FAIL after_reset_data: %h, required 12", op_data); end
        idle(BIT_CYC);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0 = perr_cnt;
        exp_q.push_back('{kind: EV_FLAG, data: 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        exp_q.push_back('{kind: EV_PERR, data: 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("parity", 4 * BIT_CYC);
        n_checks += 2;
        if (op_data !== 8'h07) begin n_fail++; $display("FAIL parity_data_held: %h, required 07", op_data); end
        if (perr_cnt != p0 + 1) begin n_fail++; $display("FAIL parity_err_count: %0d, required 1", perr_cnt - p0); end
        idle(BIT_CYC);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port op_data  output  8  last correctly received byte.
REQ-007 The block SHALL have port op_flag  output  1  one-cycle pulse, op_data newly valid.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-010 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL define BIT_MAX = CLK_FREQ/BAUD - 1 (5207 at defaults) and MID = BIT_MAX/2 using integer division (2603 at defaults).
REQ-012 The block SHALL pass rx through a 2-flop synchronizer plus one history flop, and SHALL use only the synchronized value internally.
REQ-013 The block SHALL use states IDLE, START, DATA, PARITY (present only with the macro), STOP, and WAIT_HIGH.
REQ-014 In IDLE, a synchronized falling edge SHALL move the block to START, with baud_cnt cleared to 0.
REQ-015 baud_cnt SHALL count 0..BIT_MAX and then wrap to 0 while not in IDLE/WAIT_HIGH, and SHALL be held at 0 in IDLE/WAIT_HIGH.
REQ-016 The line SHALL be sampled only on cycles where baud_cnt == MID.
REQ-017 START: a sample of 1 SHALL be treated as a false start (return to IDLE, no pulses); a sample of 0 SHALL move the block to DATA.
REQ-018 DATA: the block SHALL take 8 samples LSB first into a shift register, counted by bit_cnt 0..7; after the 8th sample it SHALL move to PARITY if enabled, else to STOP.
REQ-019 STOP: a sample of 1 with no parity error SHALL load op_data and assert op_flag on the next cycle for exactly one cycle, then return to IDLE.
REQ-020 The STOP-to-IDLE transition SHALL occur at the mid-bit sample, so that a start edge arriving half a bit later is caught (back-to-back frames, zero idle).
REQ-021 STOP: a sample of 0 SHALL pulse frame_err for one cycle, leave op_data unchanged, suppress op_flag, and move to WAIT_HIGH.
REQ-022 WAIT_HIGH SHALL return to IDLE on the first synchronized rx == 1, so that a break condition yields one frame_err only.
REQ-023 op_data SHALL hold its value between valid frames.
REQ-024 op_flag, frame_err, and parity_err SHALL never be asserted in the same cycle.
REQ-025 Worst-case latency SHALL be: start-edge detect within 3 clk cycles of the rx fall; op_flag at (9.5 or 10.5 with parity)*(BIT_MAX+1) + 4 cycles ±1 after the rx fall.

Reset
REQ-026 While rst_n is low, the block SHALL hold state = IDLE, baud_cnt = 0, bit_cnt = 0, shift register = 0, op_data = 8'h00, op_flag = 0, frame_err = 0, parity_err = 0, busy = 0, and synchronizer flops = 1.
REQ-027 A reset mid-frame SHALL abandon the frame with no pulses; after release, the block SHALL wait in IDLE for a fresh falling edge.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, the frame SHALL be start + 8 data + 1 even-parity bit + stop, sampled in state PARITY.
REQ-029 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_err in the cycle op_flag would have pulsed, suppress op_flag, and leave op_data unchanged; a stop-bit error SHALL take precedence (frame_err only).
REQ-030 Without UART_RX_PARITY_EN, the PARITY state SHALL be absent, the frame SHALL be start + 8 data + stop, and parity_err SHALL be tied to 0.

Verification
REQ-031 The bench SHALL send 0x55 at 9600 baud -> required response: one op_flag pulse, op_data = 0x55, no error pulses, busy low after the stop mid-sample.
REQ-032 The bench SHALL drive rx low for 1000 cycles, then high -> required response: no op_flag, no frame_err, return to IDLE after the START sample.
REQ-033 The bench SHALL send 0xA5 with the stop bit driven 0, then hold rx low for 3 bit times -> required response: exactly one frame_err pulse, op_data retains its prior value, and the block rearms after rx goes high.
REQ-034 The bench SHALL send 0xA5 then 0x3C back-to-back with zero idle bits -> required response: two op_flag pulses, with op_data 0xA5 then 0x3C.
REQ-035 The bench SHALL assert rst_n low during data bit 4 of 0xFF, then send 0x12 -> required response: no pulse for the aborted frame, op_data = 0x12 afterwards.
REQ-036 With UART_RX_PARITY_EN defined, the bench SHALL send 0x07 with parity 1, then 0x07 with parity 0 -> required response: op_flag with op_data 0x07, then a parity_err pulse with op_data still 0x07.
